// File: rtl/led_pkg.sv
// Shared constants for the LED sequencer family: mode encodings and direction sense.
package led_pkg;

  localparam logic [1:0] MODE_ROTATE = 2'b00;
  localparam logic [1:0] MODE_BOUNCE = 2'b01;
  localparam logic [1:0] MODE_HOLD   = 2'b10;

  localparam logic DIR_UP = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle clock-enable tick every 2**DIV_W cycles.
module tick_gen #(
  parameter int DIV_W = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Holding the count at zero while disabled makes the first tick a full period after enable.
  always_comb begin
    cnt_d = '0;
    if (en) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == '1);

endmodule

// File: rtl/led_chaser.sv
// One-hot LED sequencer with rotate, bounce and hold modes, advanced by prescaler ticks or manual steps.
module led_chaser
  import led_pkg::*;
#(
  parameter int N_LEDS = 4,
  parameter int DIV_W  = 6,
  parameter int POS_W  = $clog2(N_LEDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              dir,
  input  logic [1:0]        mode,
  input  logic              step,
  output logic [N_LEDS-1:0] leds,
  output logic [POS_W-1:0]  pos,
  output logic              wrap
);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0] PREV_POS = POS_W'(N_LEDS - 2);

  logic tick;
  logic adv;
  logic bounce_entry;
  logic bdir_eff;

  logic [POS_W-1:0] pos_q, pos_d;
  logic             bdir_q, bdir_d;
  logic             wrap_q, wrap_d;
  logic             was_bounce_q, was_bounce_d;

  tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick)
  );

  assign adv          = tick | step;
  assign bounce_entry = (mode == MODE_BOUNCE) && !was_bounce_q;
  // On the first bounce cycle the switch direction seeds bdir, and an advance in that cycle already uses it.
  assign bdir_eff     = bounce_entry ? dir : bdir_q;

  always_comb begin
    pos_d        = pos_q;
    bdir_d       = bdir_q;
    wrap_d       = 1'b0;
    was_bounce_d = (mode == MODE_BOUNCE);

    if (mode == MODE_BOUNCE) begin
      bdir_d = bdir_eff;
    end

    if (adv) begin
      case (mode)
        MODE_ROTATE: begin
          if (dir == DIR_UP) begin
            if (pos_q == LAST_POS) begin
              pos_d  = '0;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q + POS_W'(1);
            end
          end else begin
            if (pos_q == '0) begin
              pos_d  = LAST_POS;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q - POS_W'(1);
            end
          end
        end
        MODE_BOUNCE: begin
          if (bdir_eff == DIR_UP) begin
            if (pos_q == LAST_POS) begin
              pos_d  = PREV_POS;
              bdir_d = ~DIR_UP;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q + POS_W'(1);
            end
          end else begin
            if (pos_q == '0) begin
              pos_d  = POS_W'(1);
              bdir_d = DIR_UP;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q - POS_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q        <= '0;
      bdir_q       <= DIR_UP;
      wrap_q       <= 1'b0;
      was_bounce_q <= 1'b0;
    end else begin
      pos_q        <= pos_d;
      bdir_q       <= bdir_d;
      wrap_q       <= wrap_d;
      was_bounce_q <= was_bounce_d;
    end
  end

  // Decoded straight from the position register so the LED pins never see intermediate states.
  always_comb begin
    leds = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      leds[i] = (pos_q == POS_W'(i));
    end
  end

  assign pos  = pos_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_led_chaser.sv
// Randomised and directed checks of led_chaser for 4, 3 and 2 LEDs against a behavioural model.
module tb_led_chaser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic [1:0] mode;
  logic       step;

  logic [3:0] leds4;
  logic [1:0] pos4;
  logic       wrap4;
  logic [2:0] leds3;
  logic [1:0] pos3;
  logic       wrap3;
  logic [1:0] leds2;
  logic [0:0] pos2;
  logic       wrap2;

  int passCount  = 0;
  int checkCount = 0;

  int Ns[3] = '{4, 3, 2};
  int mPos[3];
  int mBdirUp[3];
  int mCnt[3];
  int mPrevBounce[3];
  int mWrap[3];

  always #5 clk = ~clk;

  led_chaser #(.N_LEDS(4), .DIV_W(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .mode(mode), .step(step),
    .leds(leds4), .pos(pos4), .wrap(wrap4)
  );

  led_chaser #(.N_LEDS(3), .DIV_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .mode(mode), .step(step),
    .leds(leds3), .pos(pos3), .wrap(wrap3)
  );

  led_chaser #(.N_LEDS(2), .DIV_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .mode(mode), .step(step),
    .leds(leds2), .pos(pos2), .wrap(wrap2)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < 3; c++) begin
      mPos[c]        = 0;
      mBdirUp[c]     = 1;
      mCnt[c]        = 0;
      mPrevBounce[c] = 0;
      mWrap[c]       = 0;
    end
  endtask

  // Behaviour at one rising edge, from the rules: tick every 4th enabled cycle, modulo rotation, reflecting bounce.
  task automatic modelEdge();
    if (!rst_n) begin
      modelReset();
      return;
    end
    for (int c = 0; c < 3; c++) begin
      int  n;
      int  target;
      bit  tick;
      bit  adv;
      bit  inBounce;
      n        = Ns[c];
      tick     = en && (mCnt[c] == 3);
      adv      = tick || step;
      inBounce = (mode == 2'b01);
      mCnt[c]  = en ? (mCnt[c] + 1) % 4 : 0;
      if (inBounce && mPrevBounce[c] == 0) mBdirUp[c] = dir;
      mWrap[c] = 0;
      if (adv) begin
        if (mode == 2'b00) begin
          target   = dir ? mPos[c] + 1 : mPos[c] - 1;
          mWrap[c] = (target < 0 || target >= n) ? 1 : 0;
          mPos[c]  = (target + n) % n;
        end else if (inBounce) begin
          target = (mBdirUp[c] != 0) ? mPos[c] + 1 : mPos[c] - 1;
          if (target < 0 || target >= n) begin
            mBdirUp[c] = (mBdirUp[c] != 0) ? 0 : 1;
            target     = (mBdirUp[c] != 0) ? mPos[c] + 1 : mPos[c] - 1;
            mWrap[c]   = 1;
          end
          mPos[c] = target;
        end
      end
      mPrevBounce[c] = inBounce ? 1 : 0;
    end
  endtask

  task automatic compareAll();
    for (int c = 0; c < 3; c++) begin
      logic [63:0] p;
      logic [63:0] l;
      logic [63:0] w;
      case (c)
        0:       begin p = 64'(pos4); l = 64'(leds4); w = 64'(wrap4); end
        1:       begin p = 64'(pos3); l = 64'(leds3); w = 64'(wrap3); end
        default: begin p = 64'(pos2); l = 64'(leds2); w = 64'(wrap2); end
      endcase
      checkOutput($sformatf("pos[N=%0d]", Ns[c]), p, 64'(mPos[c]));
      checkOutput($sformatf("leds[N=%0d]", Ns[c]), l, 64'(1) << mPos[c]);
      checkOutput($sformatf("wrap[N=%0d]", Ns[c]), w, 64'(mWrap[c]));
    end
  endtask

  task automatic applyStimulus(input logic e, input logic d, input logic [1:0] m,
                               input logic s, input int cycles);
    en   = e;
    dir  = d;
    mode = m;
    step = s;
    repeat (cycles) begin
      @(posedge clk);
      modelEdge();
      #1;
      compareAll();
    end
  endtask

  initial begin
    int firstEdge;
    int r;
    logic [1:0] rm;

    rst_n = 1'b0;
    en    = 1'b0;
    dir   = 1'b1;
    mode  = 2'b00;
    step  = 1'b0;
    modelReset();
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 2);
    checkOutput("reset leds4", 64'(leds4), 64'h1);
    rst_n = 1'b1;

    // Enable from idle: the first advance lands on the fourth edge.
    firstEdge = -1;
    en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      modelEdge();
      #1;
      compareAll();
      if (firstEdge < 0 && pos4 != 2'd0) firstEdge = i;
    end
    checkOutput("first advance edge", 64'(firstEdge), 64'd4);

    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 20);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 12);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async pos4", 64'(pos4), 64'd0);
    checkOutput("async leds4", 64'(leds4), 64'h1);
    checkOutput("async wrap4", 64'(wrap4), 64'd0);
    modelReset();
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 2);
    rst_n = 1'b1;

    // Two steps to pos 2, then bounce with dir toggling mid-run.
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 2);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 8);
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 8);
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 8);

    // Step-only operation, then a step coinciding with a tick.
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 3);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 3);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 2);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 2);
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 3);
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b1, 1);
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 4);

    // Hold with ticks and steps, then resume rotation.
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 6);
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b1, 1);
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 8);
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 10);

    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)      rm = 2'b00;
      else if (r < 8) rm = 2'b01;
      else            rm = 2'($urandom_range(2, 3));
      applyStimulus(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)), rm,
                    logic'($urandom_range(0, 5) == 0), int'($urandom_range(1, 6)));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
